// File: rtl/edge_detector.sv
//------------------------------------------------------------------------------
// Module      : edge_detector
// Description : Registered one-cycle pulse on rising, falling or both edges of
//               each din lane.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module edge_detector #(
    parameter int WIDTH     = 1,
    parameter int EDGE_MODE = 0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;

    // Unsupported mode values fall back to rising-edge detection.
    always_comb begin
        dout_d = din & ~prev_q;
        case (EDGE_MODE)
            1:       dout_d = ~din & prev_q;
            2:       dout_d = din ^ prev_q;
            default: dout_d = din & ~prev_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_q <= '0;
            dout_q <= '0;
        end else begin
            prev_q <= din;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_edge_detector.sv
//------------------------------------------------------------------------------
// Module      : tb_edge_detector
// Description : Bench for edge_detector in 1-bit rising mode and 4-bit
//               falling / both-edge modes.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_edge_detector;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic       din0   = 1'b0;
    logic [3:0] din4   = 4'h0;
    logic       dout0;
    logic [3:0] dout1;
    logic [3:0] dout2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    edge_detector #(.WIDTH(1), .EDGE_MODE(0)) u_rise (
        .clk(clk), .resetn(resetn), .din(din0), .dout(dout0));
    edge_detector #(.WIDTH(4), .EDGE_MODE(1)) u_fall (
        .clk(clk), .resetn(resetn), .din(din4), .dout(dout1));
    edge_detector #(.WIDTH(4), .EDGE_MODE(2)) u_both (
        .clk(clk), .resetn(resetn), .din(din4), .dout(dout2));

    // Reference: remembers the last sampled level per lane and decides from
    // the kind of transition seen whether a strobe is due.
    logic       last0 = 1'b0;
    logic [3:0] last4 = 4'h0;
    logic       exp0  = 1'b0;
    logic [3:0] exp1  = 4'h0;
    logic [3:0] exp2  = 4'h0;

    function automatic logic fires(input int mode, input logic was, input logic now);
        logic rising, falling;
        rising  = (was == 1'b0) && (now == 1'b1);
        falling = (was == 1'b1) && (now == 1'b0);
        if (mode == 1)      return falling;
        else if (mode == 2) return rising || falling;
        else                return rising;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last0 = 1'b0;
            last4 = 4'h0;
            exp0  = 1'b0;
            exp1  = 4'h0;
            exp2  = 4'h0;
        end else begin
            exp0 = fires(0, last0, din0);
            for (int i = 0; i < 4; i++) begin
                exp1[i] = fires(1, last4[i], din4[i]);
                exp2[i] = fires(2, last4[i], din4[i]);
            end
            last0 = din0;
            last4 = din4;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (dout0 !== exp0 || dout1 !== exp1 || dout2 !== exp2) begin
            errors++;
            $display("FAIL model t=%0t: dout0=%b dout1=%b dout2=%b expected %b %b %b",
                     $time, dout0, dout1, dout2, exp0, exp1, exp2);
        end
    end

    task automatic lit(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int pattern [7] = '{0, 0, 1, 0, 0, 1, 0};
    int npulse;
    int first_at;
    int gap;

    initial begin
        // Reset held with inputs toggling
        for (int i = 0; i < 2; i++) begin
            din0 = ~din0;
            din4 = ~din4;
            step(1);
            lit("reset_dout0", {3'b0, dout0}, 4'h0);
            lit("reset_dout2", dout2, 4'h0);
        end
        resetn = 1'b1;
        din0   = 1'b0;
        din4   = 4'h0;
        step(2);

        // Long high in rising mode
        din0 = 1'b1;
        step(1);
        lit("long_rise", {3'b0, dout0}, 4'h1);
        step(1);
        lit("long_hold", {3'b0, dout0}, 4'h0);
        step(2);
        din0 = 1'b0;
        step(1);
        lit("long_fall", {3'b0, dout0}, 4'h0);
        step(1);

        // Separated single-cycle highs
        npulse   = 0;
        first_at = -1;
        gap      = 0;
        for (int i = 0; i < 7; i++) begin
            din0 = pattern[i][0];
            step(1);
            if (dout0 === 1'b1) begin
                npulse++;
                if (first_at < 0) first_at = i;
                else gap = i - first_at;
            end
        end
        lit("sep_count", npulse[3:0], 4'd2);
        lit("sep_gap", gap[3:0], 4'd3);

        // Toggle every cycle: both-edge lanes must stay high
        for (int i = 0; i < 8; i++) begin
            din0 = ~din0;
            din4 = ~din4;
            step(1);
            if (i > 0) lit("toggle_both", dout2, 4'hF);
        end
        din0 = 1'b0;
        din4 = 4'h0;
        step(3);

        // Reset release while din is high
        din0 = 1'b1;
        step(1);
        lit("pre_reset_pulse", {3'b0, dout0}, 4'h1);
        step(2);
        resetn = 1'b0;
        step(1);
        lit("in_reset_a", {3'b0, dout0}, 4'h0);
        step(1);
        lit("in_reset_b", {3'b0, dout0}, 4'h0);
        resetn = 1'b1;
        step(1);
        lit("release_pulse", {3'b0, dout0}, 4'h1);
        step(1);
        lit("release_after", {3'b0, dout0}, 4'h0);
        step(2);

        // Asynchronous reset while a pulse is on the output
        din0 = 1'b0;
        step(2);
        din0 = 1'b1;
        step(1);
        lit("mid_pulse_high", {3'b0, dout0}, 4'h1);
        #2 resetn = 1'b0;
        #1 lit("mid_pulse_clear", {3'b0, dout0}, 4'h0);
        step(1);
        lit("mid_pulse_stay", {3'b0, dout0}, 4'h0);
        din0 = 1'b0;

        // Four lanes: release with all lanes high, then 1111 -> 0101
        din4   = 4'hF;
        resetn = 1'b1;
        step(1);
        lit("w4_release_both", dout2, 4'hF);
        lit("w4_release_fall", dout1, 4'h0);
        din4 = 4'b0101;
        step(1);
        lit("w4_fall", dout1, 4'b1010);
        lit("w4_both", dout2, 4'b1010);
        step(1);
        lit("w4_fall_end", dout1, 4'h0);
        lit("w4_both_end", dout2, 4'h0);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
